// File: rtl/datapath.sv
// datapath -- single-bus register-file datapath with a combinational ALU.
//
// Ports:
//   clk, clr                 clock, synchronous active-high clear
//   R0in..R15in, HIin, Loin, PCin, MDRin, MARin, IRin, Yin
//                            register load enables (load from bus)
//   Zin, ZHIin, ZLOin        load full Z, upper half, lower half from ALU result
//   R0out..R15out, HIout, Loout, ZHIout/ZHighSelect, ZLOout/ZLowSelect,
//   PCout, MDRout, InPortout, Cout, Yout
//                            bus source selects, priority in that order
//   MDRread                  MDR loads Mdatain (1) or bus (0)
//   IncPC                    PC <= PC + 1 when PCin is low
//   ALU_opcode               ALU operation, A = Y, B = bus
//   Mdatain                  memory read data
//   R0..R15, HI, LO, Y, ZLO, ZHI, Z_register
//                            current register contents
module datapath (
  input  logic        clk,
  input  logic        clr,
  input  logic        R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
  input  logic        R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        HIin, Loin, PCin, MDRin, MARin, IRin, Yin,
  input  logic        Zin, ZHIin, ZLOin,
  input  logic        R0out, R1out, R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
  input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        Yout, HIout, Loout, PCout, MDRout, Cout, InPortout,
  input  logic        ZHIout, ZLOout, ZHighSelect, ZLowSelect,
  input  logic        MDRread,
  input  logic        IncPC,
  input  logic [4:0]  ALU_opcode,
  input  logic [31:0] Mdatain,
  output logic [31:0] R0,  R1,  R2,  R3,  R4,  R5,  R6,  R7,
  output logic [31:0] R8,  R9,  R10, R11, R12, R13, R14, R15,
  output logic [31:0] HI, LO, Y, ZLO, ZHI,
  output logic [63:0] Z_register
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_SHR  = 5'b00101,
    OP_SHRA = 5'b00110,
    OP_SHL  = 5'b00111,
    OP_ROR  = 5'b01000,
    OP_ROL  = 5'b01001,
    OP_AND  = 5'b01010,
    OP_OR   = 5'b01011,
    OP_MUL  = 5'b01111,
    OP_DIV  = 5'b10000,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010
  } alu_op_e;

  logic [15:0] r_in, r_out;
  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

  logic [31:0] r_q [16];
  logic [31:0] r_d [16];
  logic [31:0] hi_q, hi_d, lo_q, lo_d, y_q, y_d, pc_q, pc_d;
  logic [31:0] mar_q, mar_d, mdr_q, mdr_d, ir_q, ir_d;
  logic [63:0] z_q, z_d;

  logic [31:0] bus;
  logic        bus_taken;
  logic [63:0] alu_c;
  logic [4:0]  shamt;
  logic [5:0]  shinv;
  logic [31:0] sra_res, quot, remd;
  logic signed [63:0] prod;

  // Bus: first asserted source in priority order wins, else zero.
  always_comb begin
    bus       = '0;
    bus_taken = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!bus_taken && r_out[i]) begin
        bus       = r_q[i];
        bus_taken = 1'b1;
      end
    end
    if (!bus_taken) begin
      if (HIout)                       bus = hi_q;
      else if (Loout)                  bus = lo_q;
      else if (ZHIout || ZHighSelect)  bus = z_q[63:32];
      else if (ZLOout || ZLowSelect)   bus = z_q[31:0];
      else if (PCout)                  bus = pc_q;
      else if (MDRout)                 bus = mdr_q;
      else if (InPortout)              bus = '0;
      else if (Cout)                   bus = {{13{ir_q[18]}}, ir_q[18:0]};
      else if (Yout)                   bus = y_q;
    end
  end

  // ALU: A = Y, B = bus.
  always_comb begin
    alu_c   = '0;
    shamt   = bus[4:0];
    shinv   = 6'd32 - {1'b0, shamt};
    sra_res = $signed(y_q) >>> shamt;
    prod    = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus[31]}}, bus});
    quot    = '0;
    remd    = '0;
    case (ALU_opcode)
      OP_ADD:  alu_c = {32'h0, y_q + bus};
      OP_SUB:  alu_c = {32'h0, y_q - bus};
      OP_SHR:  alu_c = {32'h0, y_q >> shamt};
      OP_SHRA: alu_c = {32'h0, sra_res};
      OP_SHL:  alu_c = {32'h0, y_q << shamt};
      // Shift by (32 - n) is zero when n = 0, so no special case is needed.
      OP_ROR:  alu_c = {32'h0, (y_q >> shamt) | (y_q << shinv)};
      OP_ROL:  alu_c = {32'h0, (y_q << shamt) | (y_q >> shinv)};
      OP_AND:  alu_c = {32'h0, y_q & bus};
      OP_OR:   alu_c = {32'h0, y_q | bus};
      OP_MUL:  alu_c = prod;
      OP_DIV: begin
        if (bus == '0) begin
          alu_c = {y_q, 32'hFFFF_FFFF};
        end else if (y_q == 32'h8000_0000 && bus == 32'hFFFF_FFFF) begin
          // Only signed overflow case: quotient wraps, remainder is zero.
          alu_c = {32'h0, y_q};
        end else begin
          quot  = $signed(y_q) / $signed(bus);
          remd  = $signed(y_q) % $signed(bus);
          alu_c = {remd, quot};
        end
      end
      OP_NEG:  alu_c = {32'h0, 32'h0 - bus};
      OP_NOT:  alu_c = {32'h0, ~bus};
      default: alu_c = '0;
    endcase
  end

  // Register next-state.
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      r_d[i] = r_in[i] ? bus : r_q[i];
    end
    hi_d  = HIin  ? bus : hi_q;
    lo_d  = Loin  ? bus : lo_q;
    y_d   = Yin   ? bus : y_q;
    mar_d = MARin ? bus : mar_q;
    ir_d  = IRin  ? bus : ir_q;
    mdr_d = MDRin ? (MDRread ? Mdatain : bus) : mdr_q;
    pc_d  = PCin  ? bus : (IncPC ? pc_q + 32'd1 : pc_q);
    z_d   = z_q;
    if (Zin) begin
      z_d = alu_c;
    end else begin
      if (ZHIin) z_d[63:32] = alu_c[63:32];
      if (ZLOin) z_d[31:0]  = alu_c[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < 16; i++) r_q[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      y_q   <= '0;
      pc_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      ir_q  <= '0;
      z_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < 16; i++) r_q[i] <= r_d[i];
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      y_q   <= y_d;
      pc_q  <= pc_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      ir_q  <= ir_d;
      z_q   <= z_d;
    end
  end

  // MAR and the IR opcode field have no consumer inside this block.
  logic unused_state;
  assign unused_state = ^{mar_q, ir_q[31:19]};

  assign R0  = r_q[0];   assign R1  = r_q[1];   assign R2  = r_q[2];   assign R3  = r_q[3];
  assign R4  = r_q[4];   assign R5  = r_q[5];   assign R6  = r_q[6];   assign R7  = r_q[7];
  assign R8  = r_q[8];   assign R9  = r_q[9];   assign R10 = r_q[10];  assign R11 = r_q[11];
  assign R12 = r_q[12];  assign R13 = r_q[13];  assign R14 = r_q[14];  assign R15 = r_q[15];
  assign HI  = hi_q;
  assign LO  = lo_q;
  assign Y   = y_q;
  assign ZLO = z_q[31:0];
  assign ZHI = z_q[63:32];
  assign Z_register = z_q;

endmodule

// File: tb/tb_datapath.sv
// Testbench for datapath: randomized and directed stimulus, expected outputs
// queued by a behavioural reference model, compared by an independent monitor.
module tb_datapath;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ien bit map: 0..15 R, then HI, LO, PC, MDR, MAR, IR, Y, Z, ZHI, ZLO
  localparam int unsigned E_HI = 16, E_LO = 17, E_PC = 18, E_MDR = 19, E_MAR = 20;
  localparam int unsigned E_IR = 21, E_Y = 22, E_Z = 23, E_ZHI = 24, E_ZLO = 25;
  // osel bit map, in bus priority order
  localparam int unsigned O_HI = 16, O_LO = 17, O_ZHI = 18, O_ZHS = 19, O_ZLO = 20;
  localparam int unsigned O_ZLS = 21, O_PC = 22, O_MDR = 23, O_IN = 24, O_C = 25, O_Y = 26;
  // observed-output index
  localparam int unsigned X_HI = 16, X_LO = 17, X_Y = 18, X_ZLO = 19, X_ZHI = 20, X_Z = 21;

  logic        clr;
  logic [25:0] ien;
  logic [26:0] osel;
  logic        mdrread, incpc;
  logic [4:0]  op;
  logic [31:0] mdat;

  logic [31:0] r_o [16];
  logic [31:0] hi_o, lo_o, y_o, zlo_o, zhi_o;
  logic [63:0] z_o;

  datapath dut (
    .clk(clk), .clr(clr),
    .R0in(ien[0]), .R1in(ien[1]), .R2in(ien[2]), .R3in(ien[3]),
    .R4in(ien[4]), .R5in(ien[5]), .R6in(ien[6]), .R7in(ien[7]),
    .R8in(ien[8]), .R9in(ien[9]), .R10in(ien[10]), .R11in(ien[11]),
    .R12in(ien[12]), .R13in(ien[13]), .R14in(ien[14]), .R15in(ien[15]),
    .HIin(ien[E_HI]), .Loin(ien[E_LO]), .PCin(ien[E_PC]), .MDRin(ien[E_MDR]),
    .MARin(ien[E_MAR]), .IRin(ien[E_IR]), .Yin(ien[E_Y]),
    .Zin(ien[E_Z]), .ZHIin(ien[E_ZHI]), .ZLOin(ien[E_ZLO]),
    .R0out(osel[0]), .R1out(osel[1]), .R2out(osel[2]), .R3out(osel[3]),
    .R4out(osel[4]), .R5out(osel[5]), .R6out(osel[6]), .R7out(osel[7]),
    .R8out(osel[8]), .R9out(osel[9]), .R10out(osel[10]), .R11out(osel[11]),
    .R12out(osel[12]), .R13out(osel[13]), .R14out(osel[14]), .R15out(osel[15]),
    .Yout(osel[O_Y]), .HIout(osel[O_HI]), .Loout(osel[O_LO]), .PCout(osel[O_PC]),
    .MDRout(osel[O_MDR]), .Cout(osel[O_C]), .InPortout(osel[O_IN]),
    .ZHIout(osel[O_ZHI]), .ZLOout(osel[O_ZLO]),
    .ZHighSelect(osel[O_ZHS]), .ZLowSelect(osel[O_ZLS]),
    .MDRread(mdrread), .IncPC(incpc), .ALU_opcode(op), .Mdatain(mdat),
    .R0(r_o[0]), .R1(r_o[1]), .R2(r_o[2]), .R3(r_o[3]),
    .R4(r_o[4]), .R5(r_o[5]), .R6(r_o[6]), .R7(r_o[7]),
    .R8(r_o[8]), .R9(r_o[9]), .R10(r_o[10]), .R11(r_o[11]),
    .R12(r_o[12]), .R13(r_o[13]), .R14(r_o[14]), .R15(r_o[15]),
    .HI(hi_o), .LO(lo_o), .Y(y_o), .ZLO(zlo_o), .ZHI(zhi_o), .Z_register(z_o)
  );

  // Reference model state
  logic [31:0] m_r [16];
  logic [31:0] m_hi, m_lo, m_y, m_pc, m_mar, m_mdr, m_ir;
  logic [63:0] m_z;

  typedef struct {
    int unsigned due;
    int unsigned idx;
    logic [63:0] val;
  } exp_t;
  exp_t sb[$];

  int unsigned cyc = 0;
  int checks = 0;
  int passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model_bus();
    logic [31:0] src [27];
    for (int i = 0; i < 16; i++) src[i] = m_r[i];
    src[O_HI]  = m_hi;
    src[O_LO]  = m_lo;
    src[O_ZHI] = m_z[63:32];
    src[O_ZHS] = m_z[63:32];
    src[O_ZLO] = m_z[31:0];
    src[O_ZLS] = m_z[31:0];
    src[O_PC]  = m_pc;
    src[O_MDR] = m_mdr;
    src[O_IN]  = 32'h0;
    src[O_C]   = {{13{m_ir[18]}}, m_ir[18:0]};
    src[O_Y]   = m_y;
    for (int i = 0; i < 27; i++) if (osel[i]) return src[i];
    return 32'h0;
  endfunction

  function automatic logic [63:0] alu_ref(logic [4:0] opc, logic [31:0] a, logic [31:0] b);
    longint sa, sb2, q, r;
    logic [63:0] aa, t;
    int unsigned n;
    sa  = $signed(a);
    sb2 = $signed(b);
    n   = b[4:0];
    aa  = {a, a};
    case (opc)
      5'b00011: return {32'h0, a + b};
      5'b00100: return {32'h0, a - b};
      5'b00101: return {32'h0, a >> n};
      5'b00110: begin t = sa >>> n; return {32'h0, t[31:0]}; end
      5'b00111: return {32'h0, a << n};
      5'b01000: begin t = aa >> n; return {32'h0, t[31:0]}; end
      5'b01001: begin t = aa << n; return {32'h0, t[63:32]}; end
      5'b01010: return {32'h0, a & b};
      5'b01011: return {32'h0, a | b};
      5'b01111: return sa * sb2;
      5'b10000: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb2;
        r = sa % sb2;
        return {r[31:0], q[31:0]};
      end
      5'b10001: return {32'h0, 32'h0 - b};
      5'b10010: return {32'h0, ~b};
      default:  return 64'h0;
    endcase
  endfunction

  task automatic push(int unsigned idx, logic [63:0] v);
    sb.push_back('{due: cyc + 1, idx: idx, val: v});
  endtask

  // Spec-given constant expectation for the result of the upcoming edge.
  task automatic expect_c(int unsigned idx, logic [63:0] v);
    push(idx, v);
  endtask

  task automatic idle();
    clr = 1'b0; ien = '0; osel = '0; mdrread = 1'b0; incpc = 1'b0;
    op = 5'b0; mdat = 32'h0;
  endtask

  // Apply current inputs for one edge, queue the model's expected state.
  task automatic tick();
    logic [31:0] b, nr [16];
    logic [31:0] nhi, nlo, ny, npc, nmar, nmdr, nir;
    logic [63:0] c, nz;
    b = model_bus();
    c = alu_ref(op, m_y, b);
    nr = m_r; nhi = m_hi; nlo = m_lo; ny = m_y; npc = m_pc;
    nmar = m_mar; nmdr = m_mdr; nir = m_ir; nz = m_z;
    if (clr) begin
      for (int i = 0; i < 16; i++) nr[i] = 32'h0;
      nhi = 0; nlo = 0; ny = 0; npc = 0; nmar = 0; nmdr = 0; nir = 0; nz = 0;
    end else begin
      for (int i = 0; i < 16; i++) if (ien[i]) nr[i] = b;
      if (ien[E_HI])  nhi  = b;
      if (ien[E_LO])  nlo  = b;
      if (ien[E_Y])   ny   = b;
      if (ien[E_MAR]) nmar = b;
      if (ien[E_IR])  nir  = b;
      if (ien[E_MDR]) nmdr = mdrread ? mdat : b;
      if (ien[E_PC])  npc  = b;
      else if (incpc) npc = m_pc + 32'd1;
      if (ien[E_Z]) nz = c;
      else begin
        if (ien[E_ZHI]) nz[63:32] = c[63:32];
        if (ien[E_ZLO]) nz[31:0]  = c[31:0];
      end
    end
    for (int i = 0; i < 16; i++) push(i, {32'h0, nr[i]});
    push(X_HI, {32'h0, nhi});
    push(X_LO, {32'h0, nlo});
    push(X_Y, {32'h0, ny});
    push(X_ZLO, {32'h0, nz[31:0]});
    push(X_ZHI, {32'h0, nz[63:32]});
    push(X_Z, nz);
    @(posedge clk);
    m_r = nr; m_hi = nhi; m_lo = nlo; m_y = ny; m_pc = npc;
    m_mar = nmar; m_mdr = nmdr; m_ir = nir; m_z = nz;
    @(negedge clk);
    idle();
  endtask

  task automatic load_mdr(logic [31:0] v);
    mdat = v; mdrread = 1'b1; ien[E_MDR] = 1'b1;
    tick();
  endtask

  task automatic mov(int unsigned src, int unsigned dst);
    osel[src] = 1'b1; ien[dst] = 1'b1;
    tick();
  endtask

  task automatic mov_chk(int unsigned src, int unsigned dst, int unsigned idx, logic [31:0] v);
    osel[src] = 1'b1; ien[dst] = 1'b1;
    expect_c(idx, {32'h0, v});
    tick();
  endtask

  task automatic set_y(logic [31:0] v);
    load_mdr(v);
    mov(O_MDR, E_Y);
  endtask

  task automatic alu_z(logic [4:0] opc, logic [31:0] a, logic [31:0] b,
                       logic [31:0] zhi_e, logic [31:0] zlo_e);
    set_y(a);
    load_mdr(b);
    osel[O_MDR] = 1'b1; op = opc; ien[E_Z] = 1'b1;
    expect_c(X_ZLO, {32'h0, zlo_e});
    expect_c(X_ZHI, {32'h0, zhi_e});
    expect_c(X_Z, {zhi_e, zlo_e});
    tick();
  endtask

  function automatic logic [63:0] dut_val(int unsigned idx);
    if (idx < 16) return {32'h0, r_o[idx]};
    case (idx)
      X_HI:    return {32'h0, hi_o};
      X_LO:    return {32'h0, lo_o};
      X_Y:     return {32'h0, y_o};
      X_ZLO:   return {32'h0, zlo_o};
      X_ZHI:   return {32'h0, zhi_o};
      default: return z_o;
    endcase
  endfunction

  function automatic string nm(int unsigned idx);
    if (idx < 16) return $sformatf("R%0d", idx);
    case (idx)
      X_HI:    return "HI";
      X_LO:    return "LO";
      X_Y:     return "Y";
      X_ZLO:   return "ZLO";
      X_ZHI:   return "ZHI";
      default: return "Z_register";
    endcase
  endfunction

  // Monitor: compares every queued expectation that has come due.
  always @(negedge clk) begin
    exp_t e;
    logic [63:0] act;
    while (sb.size() > 0) begin
      if (sb[0].due > cyc) break;
      e = sb.pop_front();
      act = dut_val(e.idx);
      checks++;
      if (e.due != cyc)
        $display("FAIL %s late cyc=%0d due=%0d", nm(e.idx), cyc, e.due);
      else if (act === e.val)
        passes++;
      else
        $display("FAIL %s cyc=%0d got=%h exp=%h", nm(e.idx), cyc, act, e.val);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  logic [4:0] ops [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                           5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
                           5'b10000, 5'b10001, 5'b10010};
  logic [31:0] specials [6] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000,
                                32'h7FFF_FFFF, 32'h1, 32'h1F};

  initial begin
    logic [31:0] b;
    int unsigned k;
    for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
    m_hi = 0; m_lo = 0; m_y = 0; m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_z = 0;
    idle();
    clr = 1'b1;
    @(negedge clk);

    // Reset with every enable and a bus source active
    clr = 1'b1; ien = '1; osel[O_MDR] = 1'b1; mdat = 32'hDEAD_BEEF; mdrread = 1'b1;
    for (int unsigned i = 0; i < 22; i++) expect_c(i, 64'h0);
    tick();

    // MDR from memory, then into R6
    load_mdr(32'h0000_0F0F);
    mov_chk(O_MDR, 6, 6, 32'h0000_0F0F);

    // Divide into split Z halves, then move halves to LO/HI
    load_mdr(32'h0000_FF0F);
    mov(O_MDR, 7);
    mov(6, E_Y);
    osel[7] = 1'b1; op = 5'b10000; ien[E_ZHI] = 1'b1; ien[E_ZLO] = 1'b1;
    tick();
    mov_chk(O_ZLO, E_LO, X_LO, 32'h0);
    mov_chk(O_ZHI, E_HI, X_HI, 32'h0000_0F0F);

    // Division rules, multiply, add
    alu_z(5'b10000, 32'h62, 32'h12, 32'h8, 32'h5);
    alu_z(5'b10000, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    alu_z(5'b10000, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    alu_z(5'b01111, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    alu_z(5'b00011, 32'h3, 32'h5, 32'h0, 32'h8);
    alu_z(5'b01000, 32'h0000_0001, 32'h0000_0021, 32'h0, 32'h8000_0000);
    alu_z(5'b01001, 32'h8000_0001, 32'h0000_0000, 32'h0, 32'h8000_0001);
    alu_z(5'b00110, 32'h8000_0000, 32'h0000_001F, 32'h0, 32'hFFFF_FFFF);
    alu_z(5'b10100, 32'h3, 32'h5, 32'h0, 32'h0);

    // PC wraps on increment
    load_mdr(32'hFFFF_FFFF);
    mov(O_MDR, E_PC);
    incpc = 1'b1;
    tick();
    mov_chk(O_PC, 1, 1, 32'h0);

    // Sign-extended IR immediate on the bus
    load_mdr(32'hFFF4_0001);
    mov(O_MDR, E_IR);
    mov_chk(O_C, 2, 2, 32'hFFFC_0001);

    // Fill everything nonzero, then clear with all enables high
    load_mdr(32'h1234_5678);
    osel[O_MDR] = 1'b1;
    for (int unsigned i = 0; i < 23; i++) ien[i] = 1'b1;
    ien[E_MDR] = 1'b0;
    tick();
    osel[O_MDR] = 1'b1; op = 5'b01111; ien[E_Z] = 1'b1;
    tick();
    clr = 1'b1; ien = '1; osel[3] = 1'b1; incpc = 1'b1;
    for (int unsigned i = 0; i < 22; i++) expect_c(i, 64'h0);
    tick();
    mov_chk(O_PC, 0, 0, 32'h0);
    mov_chk(O_MDR, 1, 1, 32'h0);
    mov_chk(O_C, 4, 4, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      ien  = 26'($urandom & $urandom & $urandom);
      osel = '0;
      k = $urandom_range(0, 7);
      if (k != 0) osel[$urandom_range(0, 26)] = 1'b1;
      if (k > 5)  osel[$urandom_range(0, 26)] = 1'b1;
      mdrread = 1'($urandom_range(0, 1));
      incpc   = ($urandom_range(0, 3) == 0);
      op      = ($urandom_range(0, 4) == 0) ? 5'($urandom) : ops[$urandom_range(0, 12)];
      mdat    = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      clr     = ($urandom_range(0, 49) == 0);
      b = model_bus();
      if (op == 5'b10000 && m_y == 32'h8000_0000 && b == 32'hFFFF_FFFF) op = 5'b00011;
      tick();
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
